// File: rtl/flood_pkg.sv
// ============================================================================
//  Module   : flood_pkg
//  Purpose  : Shared types and constants for the Flood-It move sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package flood_pkg;

    localparam int MAX_SIZE = 26;
    localparam int COLOR_W  = 3;
    localparam int COORD_W  = 5;

    localparam int N_SIZES = 7;
    localparam int LEGAL_SIZE [N_SIZES] = '{2, 6, 10, 14, 18, 22, 26};

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD_REQ   = 3'd1,
        S_LOAD_REL   = 3'd2,
        S_READY      = 3'd3,
        S_ISSUE      = 3'd4,
        S_WAIT_FLOOD = 3'd5,
        S_SCAN       = 3'd6,
        S_OVER       = 3'd7
    } state_t;

    function automatic logic is_legal_size(input int s);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < N_SIZES; i++) begin
            if (LEGAL_SIZE[i] == s) ok = 1'b1;
        end
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/board_scanner.sv
// ============================================================================
//  Module   : board_scanner
//  Purpose  : Row-major uniformity scan of the board against the corner colour.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module board_scanner #(
    parameter int COLOR_W = 3,
    parameter int COORD_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [COORD_W-1:0] size,
    input  logic [COLOR_W-1:0] data,
    output logic [COORD_W-1:0] row,
    output logic [COORD_W-1:0] col,
    output logic               done,
    output logic               match
);

    logic               r_active;
    logic               r_first;
    logic [COLOR_W-1:0] r_ref;
    logic [COORD_W-1:0] r_row;
    logic [COORD_W-1:0] r_col;

    logic [COORD_W-1:0] w_last_idx;
    logic               w_row_end;
    logic               w_last;

    assign w_last_idx = size - COORD_W'(1);
    assign w_row_end  = (r_col == w_last_idx);
    assign w_last     = w_row_end && (r_row == w_last_idx);

    // The corner cell is the reference itself, so cycle 0 always matches.
    assign match = r_first || (data == r_ref);
    assign done  = r_active && (!match || w_last);
    assign row   = r_row;
    assign col   = r_col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_first  <= 1'b0;
            r_ref    <= '0;
            r_row    <= '0;
            r_col    <= '0;
        end else if (start) begin
            r_active <= 1'b1;
            r_first  <= 1'b1;
            r_row    <= '0;
            r_col    <= '0;
        end else if (r_active) begin
            if (abort || done) begin
                r_active <= 1'b0;
                r_first  <= 1'b0;
                r_row    <= '0;
                r_col    <= '0;
            end else begin
                r_first <= 1'b0;
                if (r_first) r_ref <= data;
                if (w_row_end) begin
                    r_col <= '0;
                    r_row <= r_row + COORD_W'(1);
                end else begin
                    r_col <= r_col + COORD_W'(1);
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/game_sequencer.sv
// ============================================================================
//  Module   : game_sequencer
//  Purpose  : Flood-It move controller: load handshake, move issue, win/loss.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_sequencer #(
    parameter int MAX_SIZE = 26,
    parameter int COLOR_W  = 3,
    parameter int COORD_W  = 5,
    parameter int MOVE_W   = 6
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    input  logic               NEW_GAME_REQ,
    input  logic [COORD_W-1:0] SIZE,
    input  logic [3:0]         COLOR_NUM,
    input  logic [MOVE_W-1:0]  MOVE_LIMIT,
    input  logic [COLOR_W-1:0] COLOR_BTN,
    input  logic               COLOR_BTN_VALID,
    output logic               START_NEW_GAME,
    input  logic               STARTED_GAME,
    output logic [COLOR_W-1:0] COLOR_SELECTED,
    output logic               COLOR_SEL_SIG,
    input  logic               CHANGING_COLOR,
    output logic [COORD_W-1:0] SCAN_ROW,
    output logic [COORD_W-1:0] SCAN_COL,
    input  logic [COLOR_W-1:0] SCAN_DATA,
    output logic [MOVE_W-1:0]  MOVES,
    output logic               WON,
    output logic               LOST,
    output logic               BUSY
);

    import flood_pkg::*;

    state_t             r_state;
    state_t             w_next_state;
    logic               r_pending;
    logic [MOVE_W-1:0]  r_moves;
    logic               r_won;
    logic               r_lost;
    logic [COLOR_W-1:0] r_color;
    logic               r_start_new_game;
    logic               r_color_sel_sig;
    logic               r_busy;

    logic               w_pending;
    logic               w_pending_clr;
    logic               w_accept;
    logic               w_clear_game;
    logic               w_set_won;
    logic               w_set_lost;
    logic               w_scan_start;
    logic               w_scan_abort;
    logic               w_scan_done;
    logic               w_scan_match;
    logic               w_btn_legal;
    logic               w_limit_hit;
    logic [COORD_W-1:0] w_size_eff;

    // An out-of-list edge falls back to the full board rather than a bogus scan.
    assign w_size_eff  = is_legal_size(int'(SIZE)) ? SIZE : COORD_W'(MAX_SIZE);
    assign w_pending   = r_pending || NEW_GAME_REQ;
    assign w_btn_legal = (32'(COLOR_BTN) < 32'(COLOR_NUM)) && (COLOR_BTN != SCAN_DATA);
    assign w_limit_hit = (MOVE_LIMIT != '0) && (r_moves >= MOVE_LIMIT);
    assign w_clear_game = (w_next_state == S_LOAD_REQ) && (r_state != S_LOAD_REQ);

    board_scanner #(
        .COLOR_W (COLOR_W),
        .COORD_W (COORD_W)
    ) u_scanner (
        .clk   (CLOCK),
        .rst_n (RESET_N),
        .start (w_scan_start),
        .abort (w_scan_abort),
        .size  (w_size_eff),
        .data  (SCAN_DATA),
        .row   (SCAN_ROW),
        .col   (SCAN_COL),
        .done  (w_scan_done),
        .match (w_scan_match)
    );

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    always_comb begin
        w_next_state  = r_state;
        w_pending_clr = 1'b0;
        w_accept      = 1'b0;
        w_set_won     = 1'b0;
        w_set_lost    = 1'b0;
        w_scan_start  = 1'b0;
        w_scan_abort  = 1'b0;
        case (r_state)
            S_IDLE, S_OVER: begin
                if (w_pending) begin
                    w_next_state  = S_LOAD_REQ;
                    w_pending_clr = 1'b1;
                end
            end
            S_LOAD_REQ: if (STARTED_GAME) w_next_state = S_LOAD_REL;
            S_LOAD_REL: begin
                if (!STARTED_GAME) begin
                    w_next_state = S_SCAN;
                    w_scan_start = 1'b1;
                end
            end
            S_READY: begin
                if (w_pending) begin
                    w_next_state  = S_LOAD_REQ;
                    w_pending_clr = 1'b1;
                end else if (COLOR_BTN_VALID && w_btn_legal) begin
                    w_next_state = S_ISSUE;
                    w_accept     = 1'b1;
                end
            end
            S_ISSUE: if (CHANGING_COLOR) w_next_state = S_WAIT_FLOOD;
            S_WAIT_FLOOD: begin
                if (!CHANGING_COLOR) begin
                    w_next_state = S_SCAN;
                    w_scan_start = 1'b1;
                end
            end
            S_SCAN: begin
                if (w_pending) begin
                    w_next_state  = S_LOAD_REQ;
                    w_pending_clr = 1'b1;
                    w_scan_abort  = 1'b1;
                end else if (w_scan_done) begin
                    if (w_scan_match) begin
                        w_next_state = S_OVER;
                        w_set_won    = 1'b1;
                    end else if (w_limit_hit) begin
                        w_next_state = S_OVER;
                        w_set_lost   = 1'b1;
                    end else begin
                        w_next_state = S_READY;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pending        <= 1'b0;
            r_moves          <= '0;
            r_won            <= 1'b0;
            r_lost           <= 1'b0;
            r_color          <= '0;
            r_start_new_game <= 1'b0;
            r_color_sel_sig  <= 1'b0;
            r_busy           <= 1'b0;
        end else begin
            if (w_pending_clr)     r_pending <= 1'b0;
            else if (NEW_GAME_REQ) r_pending <= 1'b1;

            if (w_clear_game) begin
                r_moves <= '0;
                r_won   <= 1'b0;
                r_lost  <= 1'b0;
            end else begin
                if (w_accept && (r_moves != '1)) r_moves <= r_moves + MOVE_W'(1);
                if (w_set_won)  r_won  <= 1'b1;
                if (w_set_lost) r_lost <= 1'b1;
            end

            if (w_accept) r_color <= COLOR_BTN;

            r_start_new_game <= (w_next_state == S_LOAD_REQ);
            r_color_sel_sig  <= (w_next_state == S_ISSUE);
            r_busy           <= !(w_next_state inside {S_IDLE, S_READY, S_OVER});
        end
    end

    assign START_NEW_GAME = r_start_new_game;
    assign COLOR_SELECTED = r_color;
    assign COLOR_SEL_SIG  = r_color_sel_sig;
    assign MOVES          = r_moves;
    assign WON            = r_won;
    assign LOST           = r_lost;
    assign BUSY           = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_game_sequencer.sv
// ============================================================================
//  Module   : tb_game_sequencer
//  Purpose  : Directed self-checking bench for game_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_sequencer;

    import flood_pkg::*;

    logic       CLOCK = 1'b0;
    logic       RESET_N;
    logic       NEW_GAME_REQ;
    logic [4:0] SIZE;
    logic [3:0] COLOR_NUM;
    logic [5:0] MOVE_LIMIT;
    logic [2:0] COLOR_BTN;
    logic       COLOR_BTN_VALID;
    logic       START_NEW_GAME;
    logic       STARTED_GAME;
    logic [2:0] COLOR_SELECTED;
    logic       COLOR_SEL_SIG;
    logic       CHANGING_COLOR;
    logic [4:0] SCAN_ROW;
    logic [4:0] SCAN_COL;
    logic [2:0] SCAN_DATA;
    logic [5:0] MOVES;
    logic       WON;
    logic       LOST;
    logic       BUSY;

    logic [2:0] board [32][32];
    int n_tests = 0;
    int n_fail  = 0;

    assign SCAN_DATA = board[SCAN_ROW][SCAN_COL];

    always #5 CLOCK = ~CLOCK;

    game_sequencer dut (
        .CLOCK           (CLOCK),
        .RESET_N         (RESET_N),
        .NEW_GAME_REQ    (NEW_GAME_REQ),
        .SIZE            (SIZE),
        .COLOR_NUM       (COLOR_NUM),
        .MOVE_LIMIT      (MOVE_LIMIT),
        .COLOR_BTN       (COLOR_BTN),
        .COLOR_BTN_VALID (COLOR_BTN_VALID),
        .START_NEW_GAME  (START_NEW_GAME),
        .STARTED_GAME    (STARTED_GAME),
        .COLOR_SELECTED  (COLOR_SELECTED),
        .COLOR_SEL_SIG   (COLOR_SEL_SIG),
        .CHANGING_COLOR  (CHANGING_COLOR),
        .SCAN_ROW        (SCAN_ROW),
        .SCAN_COL        (SCAN_COL),
        .SCAN_DATA       (SCAN_DATA),
        .MOVES           (MOVES),
        .WON             (WON),
        .LOST            (LOST),
        .BUSY            (BUSY)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic fill_board(input logic [2:0] corner, input logic [2:0] rest);
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++)
                board[r][c] = rest;
        board[0][0] = corner;
    endtask

    task automatic wait_settled(input string tag);
        int n;
        n = 0;
        while (BUSY && n < 2000) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(BUSY), 32'd0);
    endtask

    task automatic press(input logic [2:0] c);
        COLOR_BTN       = c;
        COLOR_BTN_VALID = 1'b1;
        tick();
        COLOR_BTN_VALID = 1'b0;
    endtask

    // Press, 1-cycle flood ack, then stop on scan cycle 0.
    // mode: 0 = board untouched, 1 = corner recoloured, 2 = whole board recoloured.
    task automatic issue_move(input logic [2:0] c, input int mode);
        press(c);
        check_eq("mv_sel_sig_high", 32'(COLOR_SEL_SIG), 32'd1);
        CHANGING_COLOR = 1'b1;
        if (mode == 1) board[0][0] = c;
        if (mode == 2) fill_board(c, c);
        tick();
        check_eq("mv_sel_sig_low", 32'(COLOR_SEL_SIG), 32'd0);
        CHANGING_COLOR = 1'b0;
        tick();
    endtask

    task automatic load_game();
        NEW_GAME_REQ = 1'b1;
        tick();
        NEW_GAME_REQ = 1'b0;
        check_eq("ld_start", 32'(START_NEW_GAME), 32'd1);
        STARTED_GAME = 1'b1;
        tick();
        STARTED_GAME = 1'b0;
        check_eq("ld_release", 32'(START_NEW_GAME), 32'd0);
        tick();
        wait_settled("ld_settle");
    endtask

    initial begin
        RESET_N = 1'b0; NEW_GAME_REQ = 1'b0; SIZE = 5'd6; COLOR_NUM = 4'd4;
        MOVE_LIMIT = 6'd0; COLOR_BTN = 3'd0; COLOR_BTN_VALID = 1'b0;
        STARTED_GAME = 1'b0; CHANGING_COLOR = 1'b0;
        fill_board(3'd2, 3'd3);
        repeat (3) tick();

        // Reset state
        check_eq("rst_start",  32'(START_NEW_GAME), 32'd0);
        check_eq("rst_sel",    32'(COLOR_SEL_SIG),  32'd0);
        check_eq("rst_busy",   32'(BUSY),           32'd0);
        check_eq("rst_addr",   32'({SCAN_ROW, SCAN_COL}), 32'd0);
        check_eq("rst_result", 32'({MOVES, WON, LOST, COLOR_SELECTED}), 32'd0);
        RESET_N = 1'b1;
        tick();

        // Load handshake with a 3-cycle ack
        NEW_GAME_REQ = 1'b1;
        tick();
        NEW_GAME_REQ = 1'b0;
        check_eq("load_start_0", 32'(START_NEW_GAME), 32'd1);
        check_eq("load_busy",    32'(BUSY),           32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check_eq("load_start_hold", 32'(START_NEW_GAME), 32'd1);
        end
        STARTED_GAME = 1'b1;
        tick();
        check_eq("load_start_drop", 32'(START_NEW_GAME), 32'd0);
        STARTED_GAME = 1'b0;
        tick();
        check_eq("load_scan_busy", 32'(BUSY), 32'd1);
        tick();
        check_eq("load_scan_col1", 32'(SCAN_COL), 32'd1);
        wait_settled("load_ready");
        check_eq("load_moves0", 32'(MOVES), 32'd0);
        check_eq("load_addr0",  32'({SCAN_ROW, SCAN_COL}), 32'd0);

        // Press filtering: corner = 2, COLOR_NUM = 4
        press(3'd5);
        check_eq("filt_range_sig",   32'(COLOR_SEL_SIG), 32'd0);
        check_eq("filt_range_moves", 32'(MOVES),         32'd0);
        press(3'd2);
        check_eq("filt_same_sig",   32'(COLOR_SEL_SIG), 32'd0);
        check_eq("filt_same_moves", 32'(MOVES),         32'd0);
        issue_move(3'd1, 1);
        check_eq("filt_colour", 32'(COLOR_SELECTED), 32'd1);
        check_eq("filt_moves",  32'(MOVES),          32'd1);
        wait_settled("filt_ready");
        check_eq("filt_lost0", 32'(LOST), 32'd0);

        // Deferred new game during WAIT_FLOOD
        press(3'd3);
        check_eq("def_moves2", 32'(MOVES), 32'd2);
        CHANGING_COLOR = 1'b1;
        tick();
        NEW_GAME_REQ = 1'b1;
        tick();
        NEW_GAME_REQ = 1'b0;
        check_eq("def_no_start_a", 32'(START_NEW_GAME), 32'd0);
        tick();
        check_eq("def_no_start_b", 32'(START_NEW_GAME), 32'd0);
        CHANGING_COLOR = 1'b0;
        tick();
        check_eq("def_no_start_scan", 32'(START_NEW_GAME), 32'd0);
        tick();
        check_eq("def_start",   32'(START_NEW_GAME), 32'd1);
        check_eq("def_cleared", 32'(MOVES),          32'd0);
        STARTED_GAME = 1'b1;
        tick();
        STARTED_GAME = 1'b0;
        tick();
        wait_settled("def_ready");

        // Loss at MOVE_LIMIT = 2 (corner 1, rest 3)
        MOVE_LIMIT = 6'd2;
        issue_move(3'd2, 0);
        wait_settled("loss_ready1");
        check_eq("loss_not_yet", 32'(LOST), 32'd0);
        issue_move(3'd0, 0);
        wait_settled("loss_over");
        check_eq("loss_lost",  32'(LOST),  32'd1);
        check_eq("loss_won",   32'(WON),   32'd0);
        check_eq("loss_moves", 32'(MOVES), 32'd2);
        press(3'd2);
        check_eq("loss_press_ign", 32'({COLOR_SEL_SIG, MOVES}), 32'd2);

        // Win on a 2x2 board, verdict 4 cycles into the scan
        MOVE_LIMIT = 6'd0;
        SIZE = 5'd2;
        fill_board(3'd0, 3'd3);
        load_game();
        check_eq("win_pre_lost", 32'(LOST), 32'd0);
        issue_move(3'd3, 2);
        check_eq("win_scan_busy", 32'(BUSY), 32'd1);
        repeat (3) tick();
        check_eq("win_early", 32'(WON), 32'd0);
        tick();
        check_eq("win_won",   32'(WON),   32'd1);
        check_eq("win_busy",  32'(BUSY),  32'd0);
        check_eq("win_moves", 32'(MOVES), 32'd1);
        press(3'd1);
        check_eq("win_press_ign", 32'({COLOR_SEL_SIG, MOVES}), 32'd1);

        // Already-uniform board after load wins with zero moves
        load_game();
        check_eq("uni_won",   32'(WON),   32'd1);
        check_eq("uni_moves", 32'(MOVES), 32'd0);

        // Reset asserted mid-ISSUE
        board[1][1] = 3'd0;
        load_game();
        check_eq("ri_won0", 32'(WON), 32'd0);
        press(3'd1);
        check_eq("ri_sig_high", 32'(COLOR_SEL_SIG), 32'd1);
        #2;
        RESET_N = 1'b0;
        #1;
        check_eq("ri_sig_async", 32'(COLOR_SEL_SIG), 32'd0);
        check_eq("ri_outputs",   32'({START_NEW_GAME, BUSY, MOVES, WON, LOST, COLOR_SELECTED}), 32'd0);
        tick();
        RESET_N = 1'b1;
        tick();
        check_eq("ri_state_idle", 32'(dut.r_state), 32'(S_IDLE));
        press(3'd1);
        check_eq("ri_idle_press", 32'({COLOR_SEL_SIG, BUSY}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
